// File: rtl/psum_drain.sv
// psum_drain: sweeps a range of psum buffer rows, requantizes each row to OUT_WIDTH lanes
// and streams the result over valid/ready through a credit-limited 4-entry output FIFO.
module psum_drain #(
   parameter int ARRAY_DIM  = 16,
   parameter int ACC_WIDTH  = 32,
   parameter int OUT_WIDTH  = 8,
   parameter int DEPTH      = 1024,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start,
   input  logic [ADDR_WIDTH-1:0]          base_addr,
   input  logic [ADDR_WIDTH:0]            num_words,
   input  logic [4:0]                     shift,
   input  logic                           relu_en,
   output logic                           busy,
   output logic                           done,
   output logic [ADDR_WIDTH-1:0]          buf_addr,
   output logic                           buf_rd_en,
   input  logic [ARRAY_DIM*ACC_WIDTH-1:0] buf_rd_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [ARRAY_DIM*OUT_WIDTH-1:0] out_data,
   output logic                           out_last
);

   localparam int ROW_W      = ARRAY_DIM * OUT_WIDTH;
   localparam int FIFO_DEPTH = 4;
   localparam logic [ADDR_WIDTH:0] ZERO_CNT = {(ADDR_WIDTH+1){1'b0}};
   localparam logic [ADDR_WIDTH:0] ONE_CNT  = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH:0] DEPTH_L  = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic signed [ACC_WIDTH:0] SAT_MAX =
      $signed({{(ACC_WIDTH+2-OUT_WIDTH){1'b0}}, {(OUT_WIDTH-1){1'b1}}});
   localparam logic signed [ACC_WIDTH:0] SAT_MIN =
      $signed({{(ACC_WIDTH+2-OUT_WIDTH){1'b1}}, {(OUT_WIDTH-1){1'b0}}});

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // One extra bit of headroom keeps x + rounding constant from wrapping near +max.
   function automatic logic [OUT_WIDTH-1:0] requant_lane(
      input logic [ACC_WIDTH-1:0] x,
      input logic [4:0]           sh,
      input logic                 relu
   );
      logic signed [ACC_WIDTH:0] xe;
      logic signed [ACC_WIDTH:0] rnd;
      logic signed [ACC_WIDTH:0] y;
      logic [OUT_WIDTH-1:0]      q;
      xe  = $signed({x[ACC_WIDTH-1], x});
      rnd = (sh != 5'd0) ? $signed({{ACC_WIDTH{1'b0}}, 1'b1} << (sh - 5'd1))
                         : $signed({(ACC_WIDTH+1){1'b0}});
      y   = (xe + rnd) >>> sh;
      y   = (relu && y[ACC_WIDTH]) ? $signed({(ACC_WIDTH+1){1'b0}}) : y;
      if (y > SAT_MAX) begin
         q = SAT_MAX[OUT_WIDTH-1:0];
      end else if (y < SAT_MIN) begin
         q = SAT_MIN[OUT_WIDTH-1:0];
      end else begin
         q = y[OUT_WIDTH-1:0];
      end
      return q;
   endfunction

   state_t                  state_r;
   logic [ADDR_WIDTH-1:0]   base_r;
   logic [ADDR_WIDTH:0]     num_words_r;
   logic [ADDR_WIDTH:0]     issue_cnt_r;
   logic [4:0]              shift_r;
   logic                    relu_en_r;
   logic                    busy_r;
   logic                    done_r;
   logic                    buf_rd_en_r;
   logic [ADDR_WIDTH-1:0]   buf_addr_r;
   logic                    iss_last_r;
   logic                    rd_vld_r;
   logic                    rd_last_r;
   logic [ROW_W-1:0]        fifo_data_r [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0]   fifo_last_r;
   logic [1:0]              wr_ptr_r;
   logic [1:0]              rd_ptr_r;
   logic [2:0]              count_r;
   logic                    out_valid_r;

   logic                    push_s;
   logic                    pop_s;
   logic [2:0]              count_next_s;
   logic                    credit_ok_s;
   logic [ROW_W-1:0]        rq_row_s;
   logic [ADDR_WIDTH:0]     addr_sum_s;
   logic [ADDR_WIDTH-1:0]   next_addr_s;

   // Requantize the landing row, FIFO occupancy, issue credit and wrapped next address
   always_comb begin
      rq_row_s = {ROW_W{1'b0}};
      for (int i = 0; i < ARRAY_DIM; i++) begin
         rq_row_s[i*OUT_WIDTH +: OUT_WIDTH] =
            requant_lane(buf_rd_data[i*ACC_WIDTH +: ACC_WIDTH], shift_r, relu_en_r);
      end
      push_s       = rd_vld_r;
      pop_s        = out_valid_r & out_ready;
      count_next_s = count_r + {2'b00, push_s} - {2'b00, pop_s};
      // Entries after this edge plus the read landing next must leave room for a new issue.
      credit_ok_s  = (({1'b0, count_next_s} + {3'b000, buf_rd_en_r}) < 4'd4);
      addr_sum_s   = {1'b0, base_r} + {1'b0, issue_cnt_r[ADDR_WIDTH-1:0]};
      if (addr_sum_s >= DEPTH_L) begin
         next_addr_s = ADDR_WIDTH'(addr_sum_s - DEPTH_L);
      end else begin
         next_addr_s = ADDR_WIDTH'(addr_sum_s);
      end
   end

   // Job control FSM: captures the job, issues credit-limited reads, detects completion
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= S_IDLE;
         base_r      <= {ADDR_WIDTH{1'b0}};
         num_words_r <= ZERO_CNT;
         issue_cnt_r <= ZERO_CNT;
         shift_r     <= 5'd0;
         relu_en_r   <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         buf_rd_en_r <= 1'b0;
         buf_addr_r  <= {ADDR_WIDTH{1'b0}};
         iss_last_r  <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               done_r      <= 1'b0;
               buf_rd_en_r <= 1'b0;
               iss_last_r  <= 1'b0;
               if (start) begin
                  base_r      <= base_addr;
                  num_words_r <= num_words;
                  shift_r     <= shift;
                  relu_en_r   <= relu_en;
                  if (num_words == ZERO_CNT) begin
                     state_r     <= S_DONE;
                     done_r      <= 1'b1;
                     issue_cnt_r <= ZERO_CNT;
                  end else begin
                     state_r     <= S_ISSUE;
                     busy_r      <= 1'b1;
                     buf_rd_en_r <= 1'b1;
                     buf_addr_r  <= base_addr;
                     issue_cnt_r <= ONE_CNT;
                     iss_last_r  <= (num_words == ONE_CNT);
                  end
               end
            end
            S_ISSUE: begin
               if (issue_cnt_r == num_words_r) begin
                  state_r     <= S_DRAIN;
                  buf_rd_en_r <= 1'b0;
                  iss_last_r  <= 1'b0;
               end else if (credit_ok_s) begin
                  buf_rd_en_r <= 1'b1;
                  buf_addr_r  <= next_addr_s;
                  issue_cnt_r <= issue_cnt_r + ONE_CNT;
                  iss_last_r  <= (issue_cnt_r == (num_words_r - ONE_CNT));
               end else begin
                  buf_rd_en_r <= 1'b0;
                  iss_last_r  <= 1'b0;
               end
            end
            S_DRAIN: begin
               if ((count_next_s == 3'd0) && !rd_vld_r && !buf_rd_en_r) begin
                  state_r <= S_DONE;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
               end
            end
            S_DONE: begin
               state_r <= S_IDLE;
               done_r  <= 1'b0;
            end
            default: begin
               state_r     <= S_IDLE;
               busy_r      <= 1'b0;
               done_r      <= 1'b0;
               buf_rd_en_r <= 1'b0;
               iss_last_r  <= 1'b0;
            end
         endcase
      end
   end

   // Read-latency pipe and output FIFO; data landing from the buffer is always pushed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_vld_r    <= 1'b0;
         rd_last_r   <= 1'b0;
         wr_ptr_r    <= 2'd0;
         rd_ptr_r    <= 2'd0;
         count_r     <= 3'd0;
         out_valid_r <= 1'b0;
         fifo_last_r <= {FIFO_DEPTH{1'b0}};
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_data_r[i] <= {ROW_W{1'b0}};
         end
      end else begin
         rd_vld_r  <= buf_rd_en_r;
         rd_last_r <= iss_last_r;
         if (push_s) begin
            fifo_data_r[wr_ptr_r] <= rq_row_s;
            fifo_last_r[wr_ptr_r] <= rd_last_r;
            wr_ptr_r              <= wr_ptr_r + 2'd1;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + 2'd1;
         end
         count_r     <= count_next_s;
         out_valid_r <= (count_next_s != 3'd0);
      end
   end

   assign busy      = busy_r;
   assign done      = done_r;
   assign buf_addr  = buf_addr_r;
   assign buf_rd_en = buf_rd_en_r;
   assign out_valid = out_valid_r;
   assign out_data  = fifo_data_r[rd_ptr_r];
   assign out_last  = fifo_last_r[rd_ptr_r];

endmodule

// File: tb/tb_psum_drain.sv
// Directed self-checking bench for psum_drain with a 1-cycle-latency buffer model
// and a handshake monitor that records delivered rows, issued addresses and timing.
module tb_psum_drain;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         start = 1'b0;
   logic [9:0]   base_addr = 10'd0;
   logic [10:0]  num_words = 11'd0;
   logic [4:0]   shift = 5'd0;
   logic         relu_en = 1'b0;
   logic         busy;
   logic         done;
   logic [9:0]   buf_addr;
   logic         buf_rd_en;
   logic [511:0] buf_rd_data;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [127:0] out_data;
   logic         out_last;

   logic [511:0] mem [1024];

   int n_cmp = 0;
   int n_err = 0;

   int cyc = 0;
   int issued = 0;
   int popped = 0;
   int max_out = 0;
   int stab_err = 0;
   int start_cyc = 0;
   int first_vld_cyc = -1;
   int last_hs_cyc = 0;
   int done_cyc = 0;
   logic busy_at_done = 1'b0;
   logic hold_pend = 1'b0;
   logic [127:0] hold_d = 128'd0;
   logic hold_l = 1'b0;
   logic [127:0] dq [$];
   bit           lq [$];
   logic [9:0]   aq [$];

   psum_drain dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .base_addr   (base_addr),
      .num_words   (num_words),
      .shift       (shift),
      .relu_en     (relu_en),
      .busy        (busy),
      .done        (done),
      .buf_addr    (buf_addr),
      .buf_rd_en   (buf_rd_en),
      .buf_rd_data (buf_rd_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_last    (out_last)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      buf_rd_data <= mem[buf_addr];
   end

   // Monitor on the falling edge: handshakes, issued addresses, outstanding reads, hold stability
   always @(negedge clk) begin
      if (!rst_n) begin
         issued    <= 0;
         popped    <= 0;
         hold_pend <= 1'b0;
      end else begin
         if (start && !busy && !done) begin
            start_cyc     <= cyc;
            first_vld_cyc <= -1;
            max_out       <= 0;
         end else begin
            if (out_valid && first_vld_cyc < 0) first_vld_cyc <= cyc;
            if (issued + int'(buf_rd_en) - popped > max_out)
               max_out <= issued + int'(buf_rd_en) - popped;
         end
         if (buf_rd_en) aq.push_back(buf_addr);
         issued <= issued + int'(buf_rd_en);
         if (hold_pend && out_valid && (out_data !== hold_d || out_last !== hold_l))
            stab_err <= stab_err + 1;
         if (out_valid && out_ready) begin
            dq.push_back(out_data);
            lq.push_back(out_last);
            last_hs_cyc <= cyc;
         end
         popped    <= popped + int'(out_valid && out_ready);
         hold_pend <= out_valid && !out_ready;
         hold_d    <= out_data;
         hold_l    <= out_last;
         if (done) begin
            done_cyc     <= cyc;
            busy_at_done <= busy;
         end
      end
   end

   task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] rep8(input logic [7:0] b);
      return {16{b}};
   endfunction

   function automatic logic [127:0] pat4(input logic [7:0] b0, input logic [7:0] b1,
                                         input logic [7:0] b2, input logic [7:0] b3);
      logic [127:0] w;
      logic [7:0]   t [4];
      t[0] = b0; t[1] = b1; t[2] = b2; t[3] = b3;
      for (int i = 0; i < 16; i++) w[i*8 +: 8] = t[i % 4];
      return w;
   endfunction

   // Start a job, scramble the inputs after capture, then wait (bounded) for done
   task automatic run_job(input logic [9:0] b, input logic [10:0] n, input logic [4:0] sh,
                          input logic rl, input bit bp, input bit poke);
      bit got;
      @(posedge clk); #1;
      start = 1'b1; base_addr = b; num_words = n; shift = sh; relu_en = rl;
      @(posedge clk); #1;
      start = 1'b0; base_addr = 10'd500; num_words = 11'd7; shift = 5'd3; relu_en = 1'b1;
      check_val("busy_after_start", busy, n != 11'd0);
      check_val("rd_en_after_start", buf_rd_en, n != 11'd0);
      check_val("done_after_start", done, n == 11'd0);
      if (n != 11'd0) check_val("addr_after_start", buf_addr, b);
      got = 1'b0;
      for (int k = 0; k < 400 && !got; k++) begin
         @(negedge clk); #1;
         if (done) begin
            got = 1'b1;
         end else begin
            @(posedge clk); #1;
            if (bp) out_ready = ((k % 4) == 0) || ((k % 4) == 3);
            if (poke) start = (k == 3);
         end
      end
      start = 1'b0;
      out_ready = 1'b1;
      check_val("job_done_seen", got, 128'd1);
   endtask

   initial begin
      int qb;
      int ab;
      bit got;
      logic [127:0] w;
      logic [127:0] exp4 [4];

      for (int a = 0; a < 1024; a++) mem[a] = 512'd0;
      mem[0] = {16{32'd100}};
      mem[1] = {16{32'd200}};
      mem[2] = {16{32'hFFFF_FFCE}};
      mem[3] = {16{32'd1000}};
      for (int i = 0; i < 16; i++) begin
         case (i % 4)
            0: mem[10][i*32 +: 32] = 32'hFFFF_FFF9;
            1: mem[10][i*32 +: 32] = 32'hFFFF_FFFA;
            2: mem[10][i*32 +: 32] = 32'd5;
            default: mem[10][i*32 +: 32] = 32'd6;
         endcase
      end
      mem[11] = {8{32'h8000_0000, 32'h7FFF_FFFF}};
      for (int r = 0; r < 8; r++)
         for (int i = 0; i < 16; i++) mem[20 + r][i*32 +: 32] = 32'(r * 16 + i);
      mem[1022] = {16{32'd11}};
      mem[1023] = {16{32'd22}};

      // reset state
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      check_val("rst_busy", busy, 128'd0);
      check_val("rst_done", done, 128'd0);
      check_val("rst_rd_en", buf_rd_en, 128'd0);
      check_val("rst_addr", buf_addr, 128'd0);
      check_val("rst_valid", out_valid, 128'd0);
      check_val("rst_last", out_last, 128'd0);
      check_val("rst_data", out_data, 128'd0);
      rst_n = 1'b1;

      // basic drain
      exp4[0] = rep8(8'h64); exp4[1] = rep8(8'h7F); exp4[2] = rep8(8'hCE); exp4[3] = rep8(8'h7F);
      qb = dq.size(); ab = aq.size();
      run_job(10'd0, 11'd4, 5'd0, 1'b0, 1'b0, 1'b0);
      check_val("basic_count", dq.size() - qb, 128'd4);
      for (int i = 0; i < 4 && qb + i < dq.size(); i++) begin
         check_val("basic_data", dq[qb + i], exp4[i]);
         check_val("basic_last", lq[qb + i], i == 3);
      end
      check_val("basic_first_valid_lat", first_vld_cyc - start_cyc, 128'd3);
      check_val("basic_done_lat", done_cyc - last_hs_cyc, 128'd1);
      check_val("basic_busy_at_done", busy_at_done, 128'd0);
      @(negedge clk); #1;
      check_val("basic_done_pulse", done, 128'd0);

      // rounding, relu, saturation, no-wrap headroom
      qb = dq.size();
      run_job(10'd10, 11'd1, 5'd2, 1'b0, 1'b0, 1'b0);
      run_job(10'd10, 11'd1, 5'd2, 1'b1, 1'b0, 1'b0);
      run_job(10'd11, 11'd1, 5'd0, 1'b0, 1'b0, 1'b0);
      run_job(10'd11, 11'd1, 5'd0, 1'b1, 1'b0, 1'b0);
      run_job(10'd11, 11'd1, 5'd31, 1'b0, 1'b0, 1'b0);
      check_val("rq_count", dq.size() - qb, 128'd5);
      if (dq.size() - qb == 5) begin
         check_val("rq_round", dq[qb], pat4(8'hFE, 8'hFF, 8'h01, 8'h02));
         check_val("rq_relu", dq[qb + 1], pat4(8'h00, 8'h00, 8'h01, 8'h02));
         check_val("rq_sat", dq[qb + 2], {8{8'h80, 8'h7F}});
         check_val("rq_sat_relu", dq[qb + 3], {8{8'h00, 8'h7F}});
         check_val("rq_shift31", dq[qb + 4], {8{8'hFF, 8'h01}});
         check_val("rq_last", lq[qb + 4], 128'd1);
      end

      // backpressure with 1,0,0,1 ready pattern
      qb = dq.size(); ab = aq.size();
      run_job(10'd20, 11'd8, 5'd0, 1'b0, 1'b1, 1'b0);
      check_val("bp_count", dq.size() - qb, 128'd8);
      check_val("bp_addr_count", aq.size() - ab, 128'd8);
      for (int r = 0; r < 8 && qb + r < dq.size() && ab + r < aq.size(); r++) begin
         for (int i = 0; i < 16; i++) w[i*8 +: 8] = 8'(r * 16 + i);
         check_val("bp_data", dq[qb + r], w);
         check_val("bp_last", lq[qb + r], r == 7);
         check_val("bp_addr", aq[ab + r], 20 + r);
      end
      check_val("bp_stable", stab_err, 128'd0);
      check_val("bp_outstanding_le4", max_out <= 4, 128'd1);

      // wrap-around
      qb = dq.size(); ab = aq.size();
      run_job(10'd1022, 11'd4, 5'd0, 1'b0, 1'b0, 1'b0);
      exp4[0] = rep8(8'h0B); exp4[1] = rep8(8'h16); exp4[2] = rep8(8'h64); exp4[3] = rep8(8'h7F);
      check_val("wrap_count", dq.size() - qb, 128'd4);
      check_val("wrap_addr_count", aq.size() - ab, 128'd4);
      for (int i = 0; i < 4 && qb + i < dq.size() && ab + i < aq.size(); i++) begin
         check_val("wrap_addr", aq[ab + i], (1022 + i) % 1024);
         check_val("wrap_data", dq[qb + i], exp4[i]);
         check_val("wrap_last", lq[qb + i], i == 3);
      end

      // zero length
      qb = dq.size();
      run_job(10'd0, 11'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      check_val("zero_no_words", dq.size() - qb, 128'd0);
      @(negedge clk); #1;
      check_val("zero_done_pulse", done, 128'd0);
      check_val("zero_busy", busy, 128'd0);

      // start while busy is ignored
      qb = dq.size(); ab = aq.size();
      run_job(10'd0, 11'd4, 5'd0, 1'b0, 1'b0, 1'b1);
      exp4[0] = rep8(8'h64); exp4[1] = rep8(8'h7F); exp4[2] = rep8(8'hCE); exp4[3] = rep8(8'h7F);
      check_val("ign_count", dq.size() - qb, 128'd4);
      check_val("ign_addr_count", aq.size() - ab, 128'd4);
      for (int i = 0; i < 4 && qb + i < dq.size(); i++) begin
         check_val("ign_data", dq[qb + i], exp4[i]);
         check_val("ign_last", lq[qb + i], i == 3);
      end
      @(negedge clk); #1;
      check_val("ign_no_new_job", busy, 128'd0);

      // reset in the middle of a job
      qb = dq.size();
      @(posedge clk); #1;
      start = 1'b1; base_addr = 10'd20; num_words = 11'd8; shift = 5'd0; relu_en = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 50 && !got; k++) begin
         @(negedge clk); #1;
         if (dq.size() - qb >= 3) got = 1'b1;
      end
      check_val("mid_three_seen", got, 128'd1);
      @(posedge clk); #1;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check_val("mid_busy_before_rst", busy, 128'd1);
      rst_n = 1'b0;
      #1;
      check_val("mid_rst_busy", busy, 128'd0);
      check_val("mid_rst_done", done, 128'd0);
      check_val("mid_rst_rd_en", buf_rd_en, 128'd0);
      check_val("mid_rst_addr", buf_addr, 128'd0);
      check_val("mid_rst_valid", out_valid, 128'd0);
      check_val("mid_rst_last", out_last, 128'd0);
      check_val("mid_rst_data", out_data, 128'd0);
      check_val("mid_words_before_rst", dq.size() - qb, 128'd3);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(negedge clk); #1;
      check_val("mid_idle_after_rst", busy | out_valid | done, 128'd0);
      qb = dq.size();
      run_job(10'd0, 11'd2, 5'd0, 1'b0, 1'b0, 1'b0);
      check_val("post_rst_count", dq.size() - qb, 128'd2);
      if (dq.size() - qb == 2) begin
         check_val("post_rst_data0", dq[qb], rep8(8'h64));
         check_val("post_rst_data1", dq[qb + 1], rep8(8'h7F));
         check_val("post_rst_last0", lq[qb], 128'd0);
         check_val("post_rst_last1", lq[qb + 1], 128'd1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
